// File: rtl/aes_pkg.sv
// Shared Rijndael state geometry: legal column counts, row shift offsets and
// byte positions within a column-major state vector (S(0,0) in the MSB).
package aes_pkg;

    localparam int unsigned ROWS   = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned COL_W  = ROWS * BYTE_W;

    // Legal NB values, one 4-bit entry each.
    localparam int unsigned NB_LEGAL_N = 3;
    localparam logic [NB_LEGAL_N-1:0][3:0] NB_LEGAL = {4'd8, 4'd6, 4'd4};

    function automatic bit nb_is_legal(input int unsigned nb);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < int'(NB_LEGAL_N); i++) begin
            if (32'(NB_LEGAL[i]) == nb) ok = 1'b1;
        end
        return ok;
    endfunction

    function automatic int unsigned data_w(input int unsigned nb);
        return COL_W * nb;
    endfunction

    // Row shift offset C(r); 256-bit blocks use the wider 0,1,3,4 pattern.
    function automatic int unsigned shift_ofs(input int unsigned nb, input int unsigned r);
        int unsigned ofs;
        case (r)
            0:       ofs = 0;
            1:       ofs = 1;
            2:       ofs = (nb == 8) ? 3 : 2;
            default: ofs = (nb == 8) ? 4 : 3;
        endcase
        return ofs;
    endfunction

    function automatic int unsigned byte_idx(input int unsigned nb, input int unsigned r,
                                             input int unsigned c);
        return data_w(nb) - BYTE_W - BYTE_W * (ROWS * c + r);
    endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation; pure wiring
// steered per beat by inv_i.
module shift_rows_perm
    import aes_pkg::*;
#(
    parameter int unsigned NB = 4,
    localparam int unsigned W = data_w(NB)
) (
    input  logic [W-1:0] data_i,
    input  logic         inv_i,
    output logic [W-1:0] data_o
);

    for (genvar r = 0; r < int'(ROWS); r++) begin : g_row
        for (genvar c = 0; c < int'(NB); c++) begin : g_col
            localparam int unsigned OFS   = shift_ofs(NB, r);
            localparam int unsigned SRC_F = (c + OFS) % NB;
            localparam int unsigned SRC_I = (c + NB - OFS) % NB;

            assign data_o[byte_idx(NB, r, c) +: BYTE_W] = inv_i
                ? data_i[byte_idx(NB, r, SRC_I) +: BYTE_W]
                : data_i[byte_idx(NB, r, SRC_F) +: BYTE_W];
        end
    end

endmodule

// File: rtl/shift_rows_pipe.sv
// Elastic STAGES-deep ShiftRows/InvShiftRows stage with valid/ready
// back-pressure and a sideband tag travelling alongside each beat.
module shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int unsigned NB     = 4,
    parameter int unsigned STAGES = 1,
    parameter int unsigned TAG_W  = 4,
    localparam int unsigned W     = data_w(NB)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_inv,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [TAG_W-1:0] out_tag
);

    if (!nb_is_legal(NB)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("shift_rows_pipe: STAGES must be 1..4");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("shift_rows_pipe: TAG_W must be at least 1");
    end

    logic [W-1:0]                   perm_data;
    logic [STAGES-1:0]              vld;
    logic [STAGES-1:0][W-1:0]       dat;
    logic [STAGES-1:0][TAG_W-1:0]   tag;
    logic [STAGES-1:0]              up_vld;
    logic [STAGES-1:0][W-1:0]       up_dat;
    logic [STAGES-1:0][TAG_W-1:0]   up_tag;
    logic [STAGES:0]                rdy_c;

    shift_rows_perm #(.NB(NB)) u_perm (
        .data_i (in_data),
        .inv_i  (in_inv),
        .data_o (perm_data)
    );

    // Ready ripples back from the sink: a slot accepts if empty or draining.
    always_comb begin
        rdy_c         = '0;
        rdy_c[STAGES] = out_ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            rdy_c[k] = ~vld[k] | rdy_c[k+1];
        end
    end

    for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
        if (k == 0) begin : g_head
            assign up_vld[k] = in_valid;
            assign up_dat[k] = perm_data;
            assign up_tag[k] = in_tag;
        end else begin : g_body
            assign up_vld[k] = vld[k-1];
            assign up_dat[k] = dat[k-1];
            assign up_tag[k] = tag[k-1];
        end

        logic             v_q;
        logic [W-1:0]     d_q;
        logic [TAG_W-1:0] t_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                d_q <= '0;
                t_q <= '0;
            end else if (rdy_c[k]) begin
                v_q <= up_vld[k];
                if (up_vld[k]) begin
                    d_q <= up_dat[k];
                    t_q <= up_tag[k];
                end
            end
        end

        assign vld[k] = v_q;
        assign dat[k] = d_q;
        assign tag[k] = t_q;
    end

    assign in_ready  = rdy_c[0];
    assign out_valid = vld[STAGES-1];
    assign out_data  = dat[STAGES-1];
    assign out_tag   = tag[STAGES-1];

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Scoreboard bench: a 256-bit single-stage instance and a 128-bit three-stage
// instance, driven by directed vectors and checked by per-instance monitors.
module tb_shift_rows_pipe;

    typedef struct packed {
        logic [255:0] d;
        logic [3:0]   t;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic         a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready;
    logic [255:0] a_in_data, a_out_data;
    logic [3:0]   a_in_tag, a_out_tag;

    logic         b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready;
    logic [127:0] b_in_data, b_out_data;
    logic [3:0]   b_in_tag, b_out_tag;

    logic ready_cmd, rnd_ready, rnd_bit;
    assign b_out_ready = rnd_ready ? rnd_bit : ready_cmd;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   occ      = 0;

    always #5 clk = ~clk;

    shift_rows_pipe #(.NB(8), .STAGES(1), .TAG_W(4)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_inv(a_in_inv), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_tag(a_out_tag)
    );

    shift_rows_pipe #(.NB(4), .STAGES(3), .TAG_W(4)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_inv(b_in_inv), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_tag(b_out_tag)
    );

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // Independent reference: byte S(r,c) sits at bit w-1-8*(4c+r).
    function automatic logic [255:0] ref_perm(input int nb, input logic [255:0] d, input logic inv);
        logic [255:0] o;
        int ofs [4];
        int w, src;
        o = '0;
        w = 32 * nb;
        ofs = '{0, 1, (nb == 8) ? 3 : 2, (nb == 8) ? 4 : 3};
        for (int c = 0; c < nb; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c - ofs[r] + nb) % nb : (c + ofs[r]) % nb;
                o[w-1-8*(4*c+r) -: 8] = d[w-1-8*(4*src+r) -: 8];
            end
        end
        return o;
    endfunction

    // Offer one beat, wait (bounded) for acceptance, record its expectation.
    task automatic send_a(input logic [255:0] d, input logic inv, input logic [3:0] tg,
                          input logic [255:0] exp);
        int n;
        a_in_valid = 1'b1; a_in_data = d; a_in_inv = inv; a_in_tag = tg;
        n = 0;
        @(negedge clk);
        while (!a_in_ready && n < 200) begin n++; @(negedge clk); end
        if (!a_in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL a_accept_timeout: got in_ready=0 expected 1");
        end else begin
            qa.push_back('{d: exp, t: tg});
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [127:0] d, input logic inv, input logic [3:0] tg,
                          input logic [127:0] exp);
        int n;
        b_in_valid = 1'b1; b_in_data = d; b_in_inv = inv; b_in_tag = tg;
        n = 0;
        @(negedge clk);
        while (!b_in_ready && n < 200) begin n++; @(negedge clk); end
        if (!b_in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL b_accept_timeout: got in_ready=0 expected 1");
        end else begin
            qb.push_back('{d: 256'(exp), t: tg});
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    task automatic drain_wait();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin n++; @(negedge clk); end
        if (qa.size() != 0 || qb.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: got %0d/%0d beats pending expected 0", qa.size(), qb.size());
        end
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (!rst && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL a_unexpected_beat: got %h expected none", a_out_data);
            end else begin
                ea = qa.pop_front();
                check("a_data", a_out_data, ea.d);
                check("a_tag", 256'(a_out_tag), 256'(ea.t));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL b_unexpected_beat: got %h expected none", b_out_data);
            end else begin
                eb = qb.pop_front();
                check("b_data", 256'(b_out_data), eb.d);
                check("b_tag", 256'(b_out_tag), 256'(eb.t));
            end
        end
    end

    // Beats held by the 3-stage instance; stall only when all three slots are full.
    always @(posedge clk) begin
        if (rst) occ <= 0;
        else occ <= occ + int'(b_in_valid && b_in_ready) - int'(b_out_valid && b_out_ready);
    end

    always @(negedge clk) begin
        if (!rst) check_bit("b_in_ready_vs_occ", b_in_ready, (occ < 3) || b_out_ready);
    end

    initial forever begin
        @(posedge clk); #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] v8, e8, d8;
        logic [127:0] v4, e4, d4, d4b;
        logic         inv;

        v8 = 256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
        e8 = 256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f;
        v4 = 128'hd42711aee0bf98f1b8b45de51e415230;
        e4 = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

        rst = 1'b1; ready_cmd = 1'b1; rnd_ready = 1'b0; rnd_bit = 1'b0; a_out_ready = 1'b1;
        a_in_valid = 1'b1; a_in_data = '1; a_in_inv = 1'b0; a_in_tag = 4'hf;
        b_in_valid = 1'b1; b_in_data = '1; b_in_inv = 1'b1; b_in_tag = 4'ha;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_bit("rst_b_out_valid", b_out_valid, 1'b0);
        check("rst_b_out_data", 256'(b_out_data), '0);
        check("rst_b_out_tag", 256'(b_out_tag), '0);
        check_bit("rst_b_in_ready", b_in_ready, 1'b1);
        check_bit("rst_a_out_valid", a_out_valid, 1'b0);
        check("rst_a_out_data", a_out_data, '0);
        @(posedge clk); #1;
        rst = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0;
        repeat (2) @(posedge clk); #1;

        // 256-bit block: forward, single-cycle latency, spot bytes, then inverse.
        send_a(v8, 1'b0, 4'd3, e8);
        @(negedge clk);
        check_bit("a_latency", a_out_valid, 1'b1);
        check("a_s20", 256'(a_out_data[239 -: 8]), 256'(8'h0e));
        check("a_s30", 256'(a_out_data[231 -: 8]), 256'(8'h13));
        @(posedge clk); #1;
        send_a(e8, 1'b1, 4'd4, v8);
        for (int i = 0; i < 6; i++) begin
            d8 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            inv = (i % 2) == 1;
            send_a(d8, inv, 4'(i + 8), ref_perm(8, d8, inv));
        end
        drain_wait();

        // 128-bit block through 3 stages: FIPS-197 vector, latency, inverse.
        send_b(v4, 1'b0, 4'd5, e4);
        @(negedge clk); check_bit("b_lat_e1", b_out_valid, 1'b0);
        @(negedge clk); check_bit("b_lat_e2", b_out_valid, 1'b0);
        @(negedge clk); check_bit("b_lat_e3", b_out_valid, 1'b1);
        @(posedge clk); #1;
        send_b(e4, 1'b1, 4'd6, v4);
        drain_wait();

        // Back-to-back mixed-direction stream under random back-pressure.
        rnd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d4 = {$urandom, $urandom, $urandom, $urandom};
            inv = (i % 2) == 1;
            send_b(d4, inv, 4'(i), 128'(ref_perm(4, 256'(d4), inv)));
        end
        rnd_ready = 1'b0; ready_cmd = 1'b1;
        drain_wait();

        // Full pipe stalled for 10 cycles, then drains one beat per cycle.
        ready_cmd = 1'b0;
        send_b(v4, 1'b0, 4'd1, e4);
        d4 = {$urandom, $urandom, $urandom, $urandom};
        send_b(d4, 1'b1, 4'd2, 128'(ref_perm(4, 256'(d4), 1'b1)));
        d4 = {$urandom, $urandom, $urandom, $urandom};
        send_b(d4, 1'b0, 4'd3, 128'(ref_perm(4, 256'(d4), 1'b0)));
        d4b = {$urandom, $urandom, $urandom, $urandom};
        b_in_valid = 1'b1; b_in_data = d4b; b_in_inv = 1'b1; b_in_tag = 4'd4;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_bit("stall_in_ready", b_in_ready, 1'b0);
            check_bit("stall_out_valid", b_out_valid, 1'b1);
            check("stall_out_data", 256'(b_out_data), 256'(e4));
            check("stall_out_tag", 256'(b_out_tag), 256'(4'd1));
        end
        @(posedge clk); #1;
        ready_cmd = 1'b1;
        qb.push_back('{d: ref_perm(4, 256'(d4b), 1'b1), t: 4'd4});
        @(negedge clk); check_bit("drain_beat0", b_out_valid, 1'b1);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk); check_bit("drain_beat", b_out_valid, 1'b1);
        end
        @(posedge clk); #1;
        drain_wait();

        // Reset with two beats in flight: both must vanish.
        send_b(v4, 1'b0, 4'd7, e4);
        send_b(e4, 1'b1, 4'd8, v4);
        rst = 1'b1;
        qb.delete();
        @(posedge clk);
        @(negedge clk);
        check_bit("midrst_out_valid", b_out_valid, 1'b0);
        check("midrst_out_data", 256'(b_out_data), '0);
        check("midrst_out_tag", 256'(b_out_tag), '0);
        check_bit("midrst_in_ready", b_in_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) @(posedge clk); #1;
        drain_wait();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_rows_pipe.md
# shift_rows_pipe

Parametrised, pipelined ShiftRows / InvShiftRows stage for the Rijndael round datapath. Supports block widths of 128, 192 and 256 bits (Nb = 4, 6, 8). Direction is selectable per beat, so one instance serves both the encrypt and decrypt pipelines. Between the SubBytes and MixColumns stages it provides a STAGES-deep elastic pipeline with valid/ready back-pressure and a sideband tag that travels with the data.

## Interface
- NB, default 4: state columns; legal values 4, 6, 8; data width W = 32*NB.
- STAGES, default 1: register stages, legal 1..4; latency equals STAGES.
- TAG_W, default 4: sideband tag width (round number, stream id); at least 1.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous and active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage 0 can accept a beat.
- in_data  in  W  state; byte S(r,c) at bits [W-1-8*(4c+r) -: 8] (column-major, S(0,0) in MSB).
- in_inv  in  1  0 = ShiftRows (rotate row left), 1 = InvShiftRows (rotate row right).
- in_tag  in  TAG_W  sideband, passed unmodified.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  W  permuted state, same byte layout.
- out_tag  out  TAG_W  tag of the beat on out_data.

## Operation
- Row shift offsets C(r): NB = 4 or 6 gives 0,1,2,3. NB = 8 gives 0,1,3,4 (Rijndael).
- Forward: out S(r,c) = in S(r,(c+C(r)) mod NB).
- Inverse: out S(r,c) = in S(r,(c-C(r)+NB) mod NB).
- Row 0 is never moved. Column indices wrap modulo NB.
- The permutation is pure wiring selected by in_inv; no arithmetic on byte values.
- The permutation is applied combinationally ahead of stage-0 register. Stages 1..STAGES-1 are plain elastic registers.
- Each stage k holds valid_k, data_k and tag_k.
- A stage loads when its upstream offers a beat and the stage is empty or draining in the same cycle.
- in_ready = ~valid_0 | ready_1, where ready_k is the ready of stage k. The last stage uses out_ready.
- The ready chain is combinational, so throughput is 1 beat/cycle with no bubbles.
- in_inv is sampled per beat. Mixed forward/inverse beats stream back-to-back without a flush.
- A beat leaves when out_valid & out_ready. Data/tag on an unaccepted output stay stable until accepted.
- Illegal NB or STAGES values fail elaboration. No runtime error path.

## Timing
- Reset (rst = 1 at a clk edge) sets every valid_k = 0, data_k = 0, tag_k = 0.
- While reset is asserted, out_valid = 0, out_data = 0 and out_tag = 0.
- While reset is asserted, in_ready = 1 (stages empty). Beats offered during reset are discarded.
- Reset mid-stream drops every in-flight beat. No partial output appears after release.
- Latency: a beat accepted at edge n appears on out_data after edge n+STAGES-1 and is valid in cycle n+STAGES, assuming out_ready held high.
- Full pipeline with out_ready = 0: in_ready deasserts once all STAGES slots are valid. No beat is lost or duplicated.
- Simultaneous accept at the input and drain at the output in a full pipeline: both occur in the same cycle and occupancy stays constant.
- Ordering is strictly FIFO. Tag k always emerges with the data of beat k.

## Structure
- Shared package aes_pkg holds:
  - the NB-legal constant list;
  - the function shift_ofs(nb, r) returning C(r);
  - the function byte_idx(nb, r, c) returning the LSB position of S(r,c);
  - the W = 32*NB width rule.
- Sub-module shift_rows_perm: combinational, parameter NB, ports data_i, inv_i, data_o. Built with a generate loop over r and c.
- shift_rows_pipe instantiates one shift_rows_perm plus a generate loop of STAGES elastic register slices.

## Test plan
- NB = 4, STAGES = 1, fwd, in_data d42711aee0bf98f1b8b45de51e415230 -> out_data d4bf5d30e0b452aeb84111f11e2798e5 one cycle later, tag preserved.
- NB = 4, inv, in_data d4bf5d30e0b452aeb84111f11e2798e5 -> d42711aee0bf98f1b8b45de51e415230.
- NB = 8, fwd, in_data bytes 00..1f in order -> row 2 shifted by 3 and row 3 by 4. Check S(2,0) = in S(2,3) = 0e and S(3,0) = in S(3,4) = 13. An inverse pass restores the original.
- STAGES = 3, 16 back-to-back beats with alternating in_inv, out_ready toggling randomly -> every output equals the reference-model permutation, order and tags preserved, in_ready low only when 3 beats are held.
- out_ready = 0 for 10 cycles with a full pipe -> out_data/out_tag stable, in_ready = 0. Release -> one beat per cycle drains.
- Assert rst with 2 beats in flight -> next cycle out_valid = 0, out_data = 0, in_ready = 1. Those beats are never emitted.
